// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: bubble instruction, default reset PC, fetch FSM states.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    StReq,
    StWait,
    StHold,
    StDrop,
    StFault
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction-fetch stage: PC, single-outstanding imem handshake, IF/ID output register.
// Define IFU_MISALIGN_CHECK_EN to trap misaligned redirects in a FAULT state (fetch_misalign_o).
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] new_PC,
  output logic [31:0] instruction,
  output logic        fetch_valid
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misalign_o
`endif
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q, pc_d, pc_inc;
  logic [31:0] hold_q, hold_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] target;
  logic [31:0] deliver_data;
  logic        deliver;
  logic        accept;

`ifdef IFU_MISALIGN_CHECK_EN
  logic redirect_misalign;
  assign target            = redirect_pc_i;
  assign redirect_misalign = |redirect_pc_i[1:0];
  assign fetch_misalign_o  = (state_q == StFault);
`else
  logic unused_redirect_lsbs;
  assign target               = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
`endif

  assign pc_inc = pc_q + 32'd4;

  // A word reaches IF/ID either straight from memory or from the stall buffer.
  assign deliver = !redirect_i && !stall_i &&
                   (((state_q == StWait) && imem_rvalid_i) || (state_q == StHold));
  assign deliver_data = (state_q == StHold) ? hold_q : imem_rdata_i;
  assign accept       = imem_req_o && imem_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReq;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      case (state_q)
        // An outstanding wrong-path response must still be swallowed.
        StWait, StDrop: state_d = imem_rvalid_i ? StReq : StDrop;
        default:        state_d = StReq;
      endcase
`ifdef IFU_MISALIGN_CHECK_EN
      if (redirect_misalign) state_d = StFault;
`endif
    end else begin
      case (state_q)
        StReq:  if (accept) state_d = StWait;
        StWait: begin
          if (imem_rvalid_i) begin
            if (stall_i)     state_d = StHold;
            else if (accept) state_d = StWait;
            else             state_d = StReq;
          end
        end
        StHold: if (!stall_i) state_d = accept ? StWait : StReq;
        StDrop: if (imem_rvalid_i) state_d = StReq;
        default: state_d = state_q;
      endcase
    end
  end

  // The follow-on request goes out in the delivery cycle so zero-wait memory streams.
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = pc_q;
    if (!redirect_i) begin
      if (state_q == StReq) begin
        imem_req_o = 1'b1;
      end else if (deliver) begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_inc;
      end
    end
  end

  always_comb begin
    pc_d     = pc_q;
    hold_d   = hold_q;
    new_pc_d = new_pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    if (redirect_i) begin
      pc_d    = target;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (deliver) begin
      pc_d     = pc_inc;
      new_pc_d = pc_inc;
      instr_d  = deliver_data;
      valid_d  = 1'b1;
    end else if (!stall_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
    if (!redirect_i && stall_i && (state_q == StWait) && imem_rvalid_i) begin
      hold_d = imem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      hold_q   <= 32'h0;
      new_pc_q <= 32'h0;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      new_pc_q <= new_pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  assign new_PC      = new_pc_q;
  assign instruction = instr_q;
  assign fetch_valid = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: memory model returns ~addr for each accepted fetch.
// Builds with or without IFU_MISALIGN_CHECK_EN.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'hDEAD_BEEF;
  logic [31:0] new_PC;
  logic [31:0] instruction;
  logic        fetch_valid;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        fetch_misalign_o;
`endif

  instruction_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .new_PC        (new_PC),
    .instruction   (instruction),
    .fetch_valid   (fetch_valid)
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    .fetch_misalign_o (fetch_misalign_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          lat   = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_out(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic st, input logic rd, input logic rdr, input logic [31:0] tgt);
    @(negedge clk);
    stall_i       = st;
    imem_ready_i  = rd;
    redirect_i    = rdr;
    redirect_pc_i = tgt;
  endtask

  // Memory model: one outstanding request, response after lat cycles, data = ~addr.
  initial begin
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend          = 1'b0;
        imem_rvalid_i = 1'b0;
      end else if (pend && pend_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = ~pend_addr;
        pend          = 1'b0;
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'hDEAD_BEEF;
        if (pend) pend_cnt--;
      end
      #2;
      if (rst_n && imem_req_o && imem_ready_i) begin
        if (addr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL req_addr: got unexpected accept of %h, expected none", imem_addr_o);
        end else begin
          chk("req_addr", imem_addr_o, addr_q.pop_front());
        end
        pend      = 1'b1;
        pend_addr = imem_addr_o;
        pend_cnt  = lat - 1;
      end
    end
  end

  // Output monitor: a new IF/ID word appears only after a non-stalled cycle.
  initial begin
    logic st_last;
    exp_t e;
    forever begin
      @(posedge clk);
      st_last = stall_i;
      #1;
      if (rst_n && fetch_valid && !st_last) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_unexpected: got new_PC %h instr %h, expected none", new_PC,
                   instruction);
        end else begin
          e = exp_q.pop_front();
          chk("out_new_pc", new_PC, e.pc);
          chk("out_instr", instruction, e.instr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; imem_ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_new_pc", new_PC, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);

    for (int i = 0; i <= 16; i++) addr_q.push_back(32'(i * 4));
    for (int i = 0; i < 16; i++) push_out(32'(i * 4 + 4), ~32'(i * 4));

    cyc(0, 1, 0, 0); rst_n = 1'b1;                               // c1
    #3 chk("c1_req", {31'd0, imem_req_o}, 32'd1); chk("c1_addr", imem_addr_o, 32'h0);
    cyc(0, 1, 0, 0);                                             // c2
    #3 chk("c2_addr", imem_addr_o, 32'h4);
    cyc(0, 1, 0, 0);                                             // c3
    #3 chk("c3_valid", {31'd0, fetch_valid}, 32'd1); chk("c3_new_pc", new_PC, 32'h4);
    cyc(0, 1, 0, 0);                                             // c4
    cyc(0, 0, 0, 0);                                             // c5 ready low x3
    #3 chk("c5_addr", imem_addr_o, 32'h10);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);                                             // c7
    #3 chk("c7_req", {31'd0, imem_req_o}, 32'd1); chk("c7_addr", imem_addr_o, 32'h10);
    chk("c7_bubble", {31'd0, fetch_valid}, 32'd0);
    repeat (5) cyc(0, 1, 0, 0);                                  // c8..c12
    cyc(1, 1, 0, 0);                                             // c13 rvalid 0x20 under stall
    cyc(1, 1, 0, 0);                                             // c14
    #3 chk("stall_req", {31'd0, imem_req_o}, 32'd0); chk("stall_new_pc", new_PC, 32'h20);
    chk("stall_instr", instruction, 32'hFFFF_FFE3);
    chk("stall_valid", {31'd0, fetch_valid}, 32'd1);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);                                             // c17 release
    #3 chk("unstall_req", {31'd0, imem_req_o}, 32'd1);
    chk("unstall_addr", imem_addr_o, 32'h24);
    repeat (6) cyc(0, 1, 0, 0);                                  // c18..c23
    cyc(0, 1, 0, 0); lat = 3;                                    // c24 accept 0x40, slow

    addr_q.push_back(32'h100); addr_q.push_back(32'h104);
    push_out(32'h104, 32'hFFFF_FEFF);
    cyc(0, 1, 1, 32'h100); lat = 1;                              // c25 redirect, 0x40 pending
    #3 chk("redir_req", {31'd0, imem_req_o}, 32'd0);
    cyc(0, 1, 0, 0);                                             // c26 DROP
    #3 chk("drop_req", {31'd0, imem_req_o}, 32'd0);
    chk("drop_bubble", {31'd0, fetch_valid}, 32'd0);
    cyc(0, 1, 0, 0);                                             // c27 0x40 discarded
    #3 chk("drop_rv_req", {31'd0, imem_req_o}, 32'd0);
    cyc(0, 1, 0, 0);                                             // c28
    #3 chk("tgt_addr", imem_addr_o, 32'h100);
    cyc(0, 1, 0, 0);                                             // c29

    addr_q.push_back(32'h200); addr_q.push_back(32'h204);
    push_out(32'h204, 32'hFFFF_FDFF);
    cyc(0, 1, 1, 32'h200);                                       // c30 redirect + rvalid
    #3 chk("redir_rv_req", {31'd0, imem_req_o}, 32'd0);
    cyc(0, 1, 0, 0);                                             // c31
    #3 chk("redir_rv_addr", imem_addr_o, 32'h200);
    chk("redir_rv_bubble", {31'd0, fetch_valid}, 32'd0);
    chk("redir_rv_held_pc", new_PC, 32'h104);
    cyc(0, 1, 0, 0);                                             // c32

    addr_q.push_back(32'hFFFF_FFFC); addr_q.push_back(32'h0); addr_q.push_back(32'h4);
    push_out(32'h0, 32'h0000_0003); push_out(32'h4, 32'hFFFF_FFFF);
    push_out(32'h8, 32'hFFFF_FFFB);
    cyc(0, 1, 1, 32'hFFFF_FFFC);                                 // c33
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);                                             // c36
    #3 chk("wrap_new_pc", new_PC, 32'h0); chk("wrap_instr", instruction, 32'h0000_0003);
    repeat (4) cyc(0, 0, 0, 0);                                  // c37..c40

    for (int i = 0; i < 20 && (exp_q.size() != 0 || addr_q.size() != 0); i++) cyc(0, 0, 0, 0);
    chk("out_drained", exp_q.size(), 32'd0);
    chk("addr_drained", addr_q.size(), 32'd0);

    cyc(0, 0, 1, 32'h102);
    cyc(0, 0, 0, 0);
`ifdef IFU_MISALIGN_CHECK_EN
    #3 chk("fault_flag", {31'd0, fetch_misalign_o}, 32'd1);
    chk("fault_req", {31'd0, imem_req_o}, 32'd0);
`else
    #3 chk("align_req", {31'd0, imem_req_o}, 32'd1);
    chk("align_addr", imem_addr_o, 32'h100);
`endif
    cyc(0, 0, 1, 32'h200);
    cyc(0, 0, 0, 0);
    #3 chk("resume_req", {31'd0, imem_req_o}, 32'd1);
    chk("resume_addr", imem_addr_o, 32'h200);
`ifdef IFU_MISALIGN_CHECK_EN
    chk("fault_clear", {31'd0, fetch_misalign_o}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
